// File: rtl/pkt_dispatch_rr.sv
// Packet dispatcher: steers whole inbound packets to one of NCHAN lanes in
// round-robin order, skipping busy lanes, and records each chosen lane in a tag FIFO.
module pkt_dispatch_rr #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned NCHAN     = 4,
    parameter int unsigned TAG_DEPTH = 16,
    localparam int unsigned CH_W     = (NCHAN > 1) ? $clog2(NCHAN) : 1,
    localparam int unsigned TC_W     = $clog2(TAG_DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_sop,
    input  logic              in_eop,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [NCHAN-1:0]  out_valid,
    output logic              out_sop,
    output logic              out_eop,
    input  logic [NCHAN-1:0]  out_ready,
    output logic [7:0]        tag_data,
    output logic              tag_valid,
    input  logic              tag_ready,
    output logic [TC_W-1:0]   tag_count,
    output logic [15:0]       err_count
);
    localparam int unsigned PW  = $clog2(TAG_DEPTH);
    localparam int unsigned CW1 = CH_W + 1;

    typedef enum logic {IDLE, PKT} state_t;

    state_t          state, state_d;
    logic [CH_W-1:0] rr_ptr, rr_ptr_d, cur_lane, cur_lane_d, cand, load_lane;
    logic [CW1-1:0]  idx, cand_nxt;
    logic            cand_found, out_free, accept, load, load_sop, err_inc;
    logic            tag_push, tag_pop, tag_full;
    logic [CH_W-1:0] tag_mem [TAG_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;

    // First ready lane at or after rr_ptr, wrapping modulo NCHAN
    always_comb begin
        cand_found = 1'b0;
        cand       = '0;
        idx        = '0;
        for (int unsigned i = 0; i < NCHAN; i++) begin
            idx = CW1'(rr_ptr) + CW1'(i);
            if (idx >= CW1'(NCHAN)) idx = idx - CW1'(NCHAN);
            if (!cand_found && out_ready[idx[CH_W-1:0]]) begin
                cand_found = 1'b1;
                cand       = idx[CH_W-1:0];
            end
        end
        cand_nxt = CW1'(cand) + CW1'(1);
        if (cand_nxt >= CW1'(NCHAN)) cand_nxt = '0;
    end

    assign out_free  = ~(|out_valid) | (|(out_valid & out_ready));
    assign tag_full  = (tag_count == TC_W'(TAG_DEPTH));
    assign tag_valid = (tag_count != '0);
    assign tag_pop   = tag_valid & tag_ready;
    assign tag_data  = tag_valid ? 8'(tag_mem[rd_ptr]) : 8'h00;
    assign accept    = in_valid & in_ready;

    // Next-state, handshake and output-load decisions
    always_comb begin
        state_d    = state;
        rr_ptr_d   = rr_ptr;
        cur_lane_d = cur_lane;
        in_ready   = 1'b0;
        load       = 1'b0;
        load_lane  = cur_lane;
        load_sop   = 1'b0;
        err_inc    = 1'b0;
        tag_push   = 1'b0;
        if (reset) begin
            case (state)
                IDLE: begin
                    in_ready = in_sop ? (cand_found & out_free & ~tag_full) : 1'b1;
                    if (accept) begin
                        if (in_sop) begin
                            cur_lane_d = cand;
                            rr_ptr_d   = CH_W'(cand_nxt);
                            tag_push   = 1'b1;
                            load       = 1'b1;
                            load_lane  = cand;
                            load_sop   = 1'b1;
                            state_d    = in_eop ? IDLE : PKT;
                        end else begin
                            err_inc = 1'b1;
                        end
                    end
                end
                PKT: begin
                    in_ready = out_free;
                    if (accept) begin
                        load    = 1'b1;
                        err_inc = in_sop;
                        if (in_eop) state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cur_lane  <= '0;
            out_valid <= '0;
            out_data  <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            err_count <= '0;
        end else begin
            state    <= state_d;
            rr_ptr   <= rr_ptr_d;
            cur_lane <= cur_lane_d;
            if (load) begin
                out_valid <= NCHAN'(1) << load_lane;
                out_data  <= in_data;
                out_sop   <= load_sop;
                out_eop   <= in_eop;
            end else if (out_free) begin
                out_valid <= '0;
            end
            if (err_inc && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        end
    end

    // Tag FIFO pointers and occupancy
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            tag_count <= '0;
        end else begin
            if (tag_push) wr_ptr <= wr_ptr + PW'(1);
            if (tag_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({tag_push, tag_pop})
                2'b10:   tag_count <= tag_count + TC_W'(1);
                2'b01:   tag_count <= tag_count - TC_W'(1);
                default: tag_count <= tag_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (tag_push) tag_mem[wr_ptr] <= cand;
    end
endmodule

// File: tb/tb_pkt_dispatch_rr.sv
// Directed table-driven bench for pkt_dispatch_rr plus hand sequences for
// tag backpressure, lane stall and mid-packet reset.
module tb_pkt_dispatch_rr;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
    logic        in_ready;
    logic [63:0] out_data;
    logic [3:0]  out_valid;
    logic        out_sop, out_eop;
    logic [3:0]  out_ready = 4'hF;
    logic [7:0]  tag_data;
    logic        tag_valid;
    logic        tag_ready = 1'b0;
    logic [4:0]  tag_count;
    logic [15:0] err_count;

    int checks = 0;
    int errors = 0;

    pkt_dispatch_rr #(.DATA_W(64), .NCHAN(4), .TAG_DEPTH(16)) dut (
        .clock(clock), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
        .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_ready(out_ready),
        .tag_data(tag_data), .tag_valid(tag_valid), .tag_ready(tag_ready),
        .tag_count(tag_count), .err_count(err_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        v, s, e;
        logic [63:0] d;
        logic [3:0]  ordy;
        logic        x_rdy;
        logic [3:0]  x_ov;
        logic        x_sop, x_eop;
        logic [63:0] x_d;
        logic [15:0] x_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic v, s, e, input logic [63:0] d, input logic [3:0] ordy,
                                input logic x_rdy, input logic [3:0] x_ov, input logic x_sop, x_eop,
                                input logic [63:0] x_d, input logic [15:0] x_err);
        vec_t t;
        t.v = v; t.s = s; t.e = e; t.d = d; t.ordy = ordy;
        t.x_rdy = x_rdy; t.x_ov = x_ov; t.x_sop = x_sop; t.x_eop = x_eop;
        t.x_d = x_d; t.x_err = x_err;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one vector, check in_ready before the edge and outputs after it
    task automatic run_vec(input vec_t t, input string tag);
        in_valid = t.v; in_sop = t.s; in_eop = t.e; in_data = t.d; out_ready = t.ordy;
        #1;
        chk({tag, " in_ready"}, 64'(in_ready), 64'(t.x_rdy));
        tick();
        chk({tag, " out_valid"}, 64'(out_valid), 64'(t.x_ov));
        if (t.x_ov != 4'h0) begin
            chk({tag, " out_sop"}, 64'(out_sop), 64'(t.x_sop));
            chk({tag, " out_eop"}, 64'(out_eop), 64'(t.x_eop));
            chk({tag, " out_data"}, out_data, t.x_d);
        end
        chk({tag, " err_count"}, 64'(err_count), 64'(t.x_err));
    endtask

    initial begin
        logic [7:0] exp_tags [9];
        exp_tags = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd2, 8'd3, 8'd0, 8'd1};

        // Four 3-beat packets to lanes 0..3, then round-robin skip and protocol errors
        for (int p = 0; p < 4; p++)
            for (int b = 0; b < 3; b++)
                vecs.push_back(mk(1'b1, b == 0, b == 2, 64'(p * 16 + b), 4'hF, 1'b1, 4'(1 << p),
                                  b == 0, b == 2, 64'(p * 16 + b), 16'd0));
        vecs.push_back(mk(1, 1, 1, 64'hA0, 4'hF,    1, 4'b0001, 1, 1, 64'hA0, 16'd0));
        vecs.push_back(mk(1, 1, 1, 64'hA1, 4'b1101, 1, 4'b0100, 1, 1, 64'hA1, 16'd0));
        vecs.push_back(mk(1, 1, 1, 64'hA2, 4'hF,    1, 4'b1000, 1, 1, 64'hA2, 16'd0));
        vecs.push_back(mk(1, 1, 1, 64'hA3, 4'hF,    1, 4'b0001, 1, 1, 64'hA3, 16'd0));
        vecs.push_back(mk(1, 0, 0, 64'hBAD, 4'hF,   1, 4'b0000, 0, 0, 64'h0, 16'd1));
        vecs.push_back(mk(1, 1, 0, 64'hC0, 4'hF,    1, 4'b0010, 1, 0, 64'hC0, 16'd1));
        vecs.push_back(mk(1, 1, 0, 64'hC1, 4'hF,    1, 4'b0010, 0, 0, 64'hC1, 16'd2));
        vecs.push_back(mk(1, 0, 1, 64'hC2, 4'hF,    1, 4'b0010, 0, 1, 64'hC2, 16'd2));
        vecs.push_back(mk(0, 1, 1, 64'h0, 4'hF,     1, 4'b0000, 0, 0, 64'h0, 16'd2));

        // Reset values, with a would-be-accepted sop presented during reset
        in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b1;
        repeat (2) tick();
        chk("rst in_ready", 64'(in_ready), 64'd0);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst tag_count", 64'(tag_count), 64'd0);
        chk("rst tag_valid", 64'(tag_valid), 64'd0);
        chk("rst err_count", 64'(err_count), 64'd0);
        in_valid = 1'b0;
        reset = 1'b1;
        tick();

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Tags come out in dispatch order
        chk("tag_count after table", 64'(tag_count), 64'd9);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("tag_valid%0d", i), 64'(tag_valid), 64'd1);
            chk($sformatf("tag_data%0d", i), 64'(tag_data), 64'(exp_tags[i]));
            tag_ready = 1'b1;
            tick();
            tag_ready = 1'b0;
        end
        chk("tag drained", 64'(tag_count), 64'd0);

        // Fill the tag FIFO with 16 single-beat packets; rr_ptr starts at 2
        for (int k = 0; k < 16; k++)
            run_vec(mk(1, 1, 1, 64'(16'hE00 + k), 4'hF, 1, 4'(1 << ((2 + k) % 4)), 1, 1,
                       64'(16'hE00 + k), 16'd2), $sformatf("fill%0d", k));
        chk("tag_count full", 64'(tag_count), 64'd16);
        in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b1; in_data = 64'hF0;
        #1;
        chk("full in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("full stall out_valid", 64'(out_valid), 64'd0);
        chk("full stall tag_count", 64'(tag_count), 64'd16);
        tag_ready = 1'b1;
        #1;
        chk("full pop-cycle in_ready", 64'(in_ready), 64'd0);
        tick();
        tag_ready = 1'b0;
        chk("after pop tag_count", 64'(tag_count), 64'd15);
        #1;
        chk("after pop in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("17th out_valid", 64'(out_valid), 64'b0100);
        chk("17th out_data", out_data, 64'hF0);
        chk("17th tag_count", 64'(tag_count), 64'd16);
        tag_ready = 1'b1;
        repeat (16) tick();
        tag_ready = 1'b0;
        chk("refill drained", 64'(tag_count), 64'd0);

        // Lane 3 stalls mid-packet for 5 cycles; rr_ptr is 3
        run_vec(mk(1, 1, 0, 64'hD0, 4'hF, 1, 4'b1000, 1, 0, 64'hD0, 16'd2), "stall D0");
        run_vec(mk(1, 0, 0, 64'hD1, 4'hF, 1, 4'b1000, 0, 0, 64'hD1, 16'd2), "stall D1");
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b0; in_data = 64'hD2; out_ready = 4'b0111;
            #1;
            chk($sformatf("stall%0d in_ready", c), 64'(in_ready), 64'd0);
            tick();
            chk($sformatf("stall%0d out_valid", c), 64'(out_valid), 64'b1000);
            chk($sformatf("stall%0d out_data", c), out_data, 64'hD1);
        end
        run_vec(mk(1, 0, 0, 64'hD2, 4'hF, 1, 4'b1000, 0, 0, 64'hD2, 16'd2), "stall D2");
        run_vec(mk(1, 0, 1, 64'hD3, 4'hF, 1, 4'b1000, 0, 1, 64'hD3, 16'd2), "stall D3");
        run_vec(mk(0, 0, 0, 64'h0, 4'hF, 1, 4'b0000, 0, 0, 64'h0, 16'd2), "stall idle");

        // Reset pulsed mid-packet; rr_ptr is 0
        run_vec(mk(1, 1, 0, 64'hE0, 4'hF, 1, 4'b0001, 1, 0, 64'hE0, 16'd2), "mrst E0");
        run_vec(mk(1, 0, 0, 64'hE1, 4'hF, 1, 4'b0001, 0, 0, 64'hE1, 16'd2), "mrst E1");
        in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b0; in_data = 64'hE2;
        reset = 1'b0;
        #1;
        chk("mrst out_valid", 64'(out_valid), 64'd0);
        chk("mrst out_sop", 64'(out_sop), 64'd0);
        chk("mrst out_eop", 64'(out_eop), 64'd0);
        chk("mrst out_data", out_data, 64'd0);
        chk("mrst in_ready", 64'(in_ready), 64'd0);
        chk("mrst tag_count", 64'(tag_count), 64'd0);
        chk("mrst tag_data", 64'(tag_data), 64'd0);
        chk("mrst err_count", 64'(err_count), 64'd0);
        in_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        tick();
        run_vec(mk(1, 0, 0, 64'hE3, 4'hF, 1, 4'b0000, 0, 0, 64'h0, 16'd1), "post-rst no-sop");
        run_vec(mk(1, 1, 1, 64'hE4, 4'hF, 1, 4'b0001, 1, 1, 64'hE4, 16'd1), "post-rst sop");
        in_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
